// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access: one Wishbone-classic transfer per load/store, byte lanes, load align/extend.
// Optional MEM_BUS_TIMEOUT_EN: abandon a BUSY transfer after TIMEOUT_CYCLES and pulse bus_error_out.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] store_data_in,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  mem_stall_out,
  output logic                  fault_out,
  output logic                  bus_error_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic       req, bad_f3, issue, ack_done, expire;
  logic [3:0] sel_nxt;
  logic [DATA_WIDTH-1:0] dat_nxt, ld_ext;
  logic [2:0] ld_f3;
  logic [1:0] ld_off;
  logic       is_load;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    req    = mem_read_in | mem_write_in;
    bad_f3 = !(funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    fault_out = req & (bad_f3
                     | ((funct3_in[1:0] == 2'b01) & addr_in[0])
                     | ((funct3_in == 3'b010) & (addr_in[1:0] != 2'b00))
                     | (mem_read_in & mem_write_in));
    issue         = (state == IDLE) & req & !fault_out;
    ack_done      = (state == BUSY) & wb_ack_i;
    mem_stall_out = issue | (state == BUSY);
  end

  // Stores replicate the datum across lanes so the slave can pick any lane sel enables.
  always_comb begin
    sel_nxt = 4'b1111;
    dat_nxt = store_data_in;
    if (mem_write_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          sel_nxt = 4'b0001 << addr_in[1:0];
          dat_nxt = {4{store_data_in[7:0]}};
        end
        2'b01: begin
          sel_nxt = 4'b0011 << addr_in[1:0];
          dat_nxt = {2{store_data_in[15:0]}};
        end
        default: sel_nxt = 4'b1111;
      endcase
    end
  end

  always_comb begin
    ld_byte = wb_dat_i[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
    case (ld_f3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = wb_dat_i;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                to_cnt <= '0;
    else if (issue)           to_cnt <= '0;
    else if (state == BUSY)   to_cnt <= to_cnt + 1'b1;
  end

  // An ack in the expiry cycle takes priority and completes normally.
  assign expire = (state == BUSY) & !wb_ack_i & (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus_error_out <= 1'b0;
    else       bus_error_out <= expire;
  end
`else
  assign expire        = 1'b0;
  assign bus_error_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (ack_done | expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= 4'b0000;
      load_data_out <= '0;
      ld_f3         <= 3'b000;
      ld_off        <= 2'b00;
      is_load       <= 1'b0;
    end else if (issue) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= mem_write_in;
      wb_adr_o <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
      wb_dat_o <= dat_nxt;
      wb_sel_o <= sel_nxt;
      ld_f3    <= funct3_in;
      ld_off   <= addr_in[1:0];
      is_load  <= mem_read_in;
    end else if (ack_done | expire) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      if (ack_done && is_load) load_data_out <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized + directed bench for mem_access_stage against a behavioural model of the RV32I access rules.
module tb_mem_access_stage;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, store_data_in;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [31:0] load_data_out;
  logic        mem_stall_out, fault_out, bus_error_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_load = 32'd0;

  mem_access_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .load_data_out(load_data_out), .mem_stall_out(mem_stall_out),
    .fault_out(fault_out), .bus_error_out(bus_error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: access size in bytes, lanes, replication, extraction ----
  function automatic int m_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a);
    logic legal;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (!legal) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!wr) return 4'hF;
    n = m_size(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_dat(input logic [2:0] f3, input logic [31:0] d);
    case (m_size(f3))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    longint v, span;
    int n;
    n = m_size(f3);
    if (n == 4) return rdata;
    span = longint'(1) << (8 * n);
    v = (longint'(rdata) >> (8 * (a % 4))) % span;
    if (f3[2] == 1'b0 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Drive one request starting at a negedge in IDLE; returns at DONE negedge with req dropped.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int waits, input logic [31:0] rdata);
    logic flt;
    flt = m_fault(rd, wr, f3, a);
    @(negedge clk);
    mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = a; store_data_in = sd;
    #1;
    check("fault", 32'(fault_out), 32'(flt));
    check("stall_issue", 32'(mem_stall_out), 32'(!flt));
    @(posedge clk);
    if (flt) begin
      @(negedge clk); #1;
      check("fault_nocyc", 32'(wb_cyc_o), 32'd0);
      check("fault_nostall", 32'(mem_stall_out), 32'd0);
      mem_read_in = 1'b0; mem_write_in = 1'b0;
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      wb_ack_i = (w == waits);
      wb_dat_i = (w == waits) ? rdata : $urandom;
      #1;
      check("busy_cyc", 32'(wb_cyc_o), 32'd1);
      check("busy_stb", 32'(wb_stb_o), 32'd1);
      check("busy_we", 32'(wb_we_o), 32'(wr));
      check("busy_adr", wb_adr_o, a & 32'hFFFF_FFFC);
      check("busy_sel", 32'(wb_sel_o), 32'(m_sel(wr, f3, a)));
      if (wr) check("busy_dat", wb_dat_o, m_dat(f3, sd));
      check("busy_stall", 32'(mem_stall_out), 32'd1);
    end
    @(negedge clk);
    wb_ack_i = 1'b0;
    #1;
    if (rd) exp_load = m_load(f3, a, rdata);
    check("done_cyc", 32'(wb_cyc_o), 32'd0);
    check("done_stb", 32'(wb_stb_o), 32'd0);
    check("done_stall", 32'(mem_stall_out), 32'd0);
    check("done_load", load_data_out, exp_load);
    check("done_buserr", 32'(bus_error_out), 32'd0);
    mem_read_in = 1'b0; mem_write_in = 1'b0;
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    logic rd;
    reset = 1'b1;
    mem_read_in = 0; mem_write_in = 0; funct3_in = 0; addr_in = 0; store_data_in = 0;
    wb_dat_i = 0; wb_ack_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_we", 32'(wb_we_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_sel", 32'(wb_sel_o), 32'd0);
    check("rst_load", load_data_out, 32'd0);
    check("rst_buserr", 32'(bus_error_out), 32'd0);
    reset = 1'b0;

    do_access(1, 0, 3'b010, 32'h8000_0104, 0, 0, 32'hDEAD_BEEF);
    check("lw_const", load_data_out, 32'hDEAD_BEEF);
    do_access(1, 0, 3'b000, 32'h8000_0003, 0, 1, 32'h80FF_FF7F);
    check("lb_const", load_data_out, 32'hFFFF_FF80);
    do_access(1, 0, 3'b100, 32'h8000_0003, 0, 0, 32'h80FF_FF7F);
    check("lbu_const", load_data_out, 32'h0000_0080);
    do_access(1, 0, 3'b101, 32'h8000_0002, 0, 2, 32'h80FF_FF7F);
    check("lhu_const", load_data_out, 32'h0000_80FF);
    do_access(0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 3, 32'h0);
    check("sh_hold", load_data_out, 32'h0000_80FF);
    do_access(1, 0, 3'b010, 32'h8000_0001, 0, 0, 0);
    do_access(1, 0, 3'b011, 32'h8000_0000, 0, 0, 0);
    do_access(1, 1, 3'b010, 32'h8000_0000, 0, 0, 0);

    // reset in BUSY, then a stray ack in IDLE
    @(negedge clk);
    mem_read_in = 1; funct3_in = 3'b010; addr_in = 32'h8000_0010;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; mem_read_in = 0;
    #1;
    check("rstbusy_cyc", 32'(wb_cyc_o), 32'd0);
    check("rstbusy_stb", 32'(wb_stb_o), 32'd0);
    check("rstbusy_stall", 32'(mem_stall_out), 32'd0);
    @(negedge clk);
    reset = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    @(negedge clk);
    wb_ack_i = 1'b0; #1;
    check("stray_cyc", 32'(wb_cyc_o), 32'd0);
    check("stray_load", load_data_out, 32'd0);
    exp_load = 32'd0;
    do_access(1, 0, 3'b001, 32'h8000_0022, 0, 1, 32'h8765_4321);

    for (int i = 0; i < 40; i++) begin
      rd = $urandom_range(0, 1);
      if (rd) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a = a - (a % m_size(f3));
      do_access(rd, !rd, f3, a, $urandom, $urandom_range(0, 3), $urandom);
    end

`ifdef MEM_BUS_TIMEOUT_EN
    begin
      logic [31:0] held;
      held = load_data_out;
      @(negedge clk);
      mem_read_in = 1; funct3_in = 3'b010; addr_in = 32'h8000_0040;
      @(posedge clk);
      for (int c = 0; c < TO; c++) begin
        @(negedge clk); #1;
        check("to_busy_cyc", 32'(wb_cyc_o), 32'd1);
      end
      @(negedge clk); #1;
      check("to_done_cyc", 32'(wb_cyc_o), 32'd0);
      check("to_buserr", 32'(bus_error_out), 32'd1);
      check("to_load", load_data_out, held);
      mem_read_in = 0;
      @(negedge clk); #1;
      check("to_buserr_end", 32'(bus_error_out), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
